alu_seq: RTL and testbench

Parametrised, registered successor to the combinational 4-bit ALU. It keeps the same operation encoding: L selects arithmetic or logic, and Op selects within the group. Operand width is generalised to WIDTH. Results and flags are registered, and a start/busy/done handshake is added. A multi-cycle unsigned shift-add multiply mode is also added. The block sits between the register file and the datapath result bus of the teaching CPU.

---
 rtl/alu_seq.sv | 215 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake and shift-add multiply.
// Define ALU_OVF_FLAG_EN to add the signed-overflow output v.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             l,
  input  logic [1:0]       op,
  input  logic             mul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic             z,
  output logic             c,
  output logic             s,
  output logic             busy,
  output logic             done
`ifdef ALU_OVF_FLAG_EN
  ,
  output logic             v
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             l_q, l_d;
  logic [1:0]       op_q, op_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             c_q, c_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] yb;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c;
  logic [PW-1:0]    prod_nxt;
  logic             mul_last;

  // b_q doubles as the multiplier shift register in MUL
  assign prod_nxt = prod_q + (b_q[0] ? mcand_q : '0);
  assign mul_last = (state_q == MUL) && (cnt_q == CW'(1));

  always_comb begin
    x   = a_q;
    yb  = '0;
    cin = 1'b0;
    unique case (op_q)
      2'b00: begin x = a_q;  cin = 1'b1; end
      2'b01: begin x = ~b_q; cin = 1'b1; end
      2'b10: begin x = a_q;  yb = b_q; end
      2'b11: begin
        x   = a_q;
        yb  = ~b_q;
        cin = 1'b1;
      end
    endcase
    sum = {1'b0, x} + {1'b0, yb}
        + {{WIDTH{1'b0}}, cin};
    alu_r = sum[WIDTH-1:0];
    alu_c = sum[WIDTH];
    if (l_q) begin
      alu_c = 1'b0;
      unique case (op_q)
        2'b00: alu_r = a_q & b_q;
        2'b01: alu_r = a_q | b_q;
        2'b10: alu_r = a_q ^ b_q;
        2'b11: alu_r = ~a_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    l_d     = l_q;
    op_d    = op_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    c_d     = c_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d    = a;
          b_d    = b;
          l_d    = l;
          op_d   = op;
          busy_d = 1'b1;
          if (mul) begin
            state_d = MUL;
            cnt_d   = CW'(WIDTH);
            prod_d  = '0;
            mcand_d = {{WIDTH{1'b0}}, a};
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        r_d     = alu_r;
        c_d     = alu_c;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      MUL: begin
        prod_d  = prod_nxt;
        mcand_d = mcand_q << 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q - CW'(1);
        if (mul_last) begin
          r_d     = prod_nxt[WIDTH-1:0];
          c_d     = |prod_nxt[PW-1:WIDTH];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      l_q     <= 1'b0;
      op_q    <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      l_q     <= l_d;
      op_q    <= op_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign r    = r_q;
  assign z    = ~|r_q;
  assign s    = r_q[WIDTH-1];
  assign c    = c_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef ALU_OVF_FLAG_EN
  logic             v_q, v_d;
  logic             y_sign;
  logic [WIDTH-1:0] b_neg;
  logic             alu_v;

  assign b_neg = ~b_q + WIDTH'(1);

  // adder Y input sign: 1 for inc/neg, B for add, -B for sub
  always_comb begin
    y_sign = 1'b0;
    if (op_q == 2'b10) y_sign = b_q[WIDTH-1];
    if (op_q == 2'b11) y_sign = b_neg[WIDTH-1];
    alu_v = ~l_q
          & (x[WIDTH-1] == y_sign)
          & (sum[WIDTH-1] != x[WIDTH-1]);
  end

  always_comb begin
    v_d = v_q;
    if (state_q == EXEC) v_d = alu_v;
    if (mul_last)        v_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) v_q <= 1'b0;
    else       v_q <= v_d;
  end

  assign v = v_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: WIDTH=4 and WIDTH=8 instances against a
// behavioural arithmetic model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start4 = 1'b0;
  logic        start8 = 1'b0;
  logic        l_in = 1'b0;
  logic [1:0]  op_in = 2'b00;
  logic        mul_in = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;

  logic [3:0]  r4;
  logic        z4, c4, s4, busy4, done4;
  logic [7:0]  r8;
  logic        z8, c8, s8, busy8, done8;
`ifdef ALU_OVF_FLAG_EN
  logic        v4, v8;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(4)) u4 (
    .clk(clk), .reset(reset), .start(start4),
    .l(l_in), .op(op_in), .mul(mul_in),
    .a(a_in[3:0]), .b(b_in[3:0]),
    .r(r4), .z(z4), .c(c4), .s(s4),
    .busy(busy4), .done(done4)
`ifdef ALU_OVF_FLAG_EN
    , .v(v4)
`endif
  );

  alu_seq #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8),
    .l(l_in), .op(op_in), .mul(mul_in),
    .a(a_in[7:0]), .b(b_in[7:0]),
    .r(r8), .z(z8), .c(c8), .s(s8),
    .busy(busy8), .done(done8)
`ifdef ALU_OVF_FLAG_EN
    , .v(v8)
`endif
  );

  // Reference: results from plain integer arithmetic on the operands
  function automatic void model(
    input int w, input bit l, input int op, input bit m,
    input longint a, input longint b,
    output longint r, output bit c, output bit v);
    longint mask, half, p, sx, sy, tot;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    c = 1'b0;
    v = 1'b0;
    sx = 0;
    sy = 0;
    if (m) begin
      p = a * b;
      r = p & mask;
      c = (p >> w) != 0;
    end else if (l) begin
      case (op)
        0: r = a & b;
        1: r = a | b;
        2: r = a ^ b;
        default: r = (~a) & mask;
      endcase
    end else begin
      case (op)
        0: begin r = (a + 1) & mask; c = (a == mask);
                 sx = a; sy = 1; end
        1: begin r = (-b) & mask; c = (b == 0);
                 sx = (~b) & mask; sy = 1; end
        2: begin r = (a + b) & mask; c = (a + b) > mask;
                 sx = a; sy = b; end
        default: begin r = (a - b) & mask; c = (a >= b);
                 sx = a; sy = (-b) & mask; end
      endcase
      if (sx >= half) sx = sx - (mask + 1);
      if (sy >= half) sy = sy - (mask + 1);
      tot = sx + sy;
      v = (tot > half - 1) || (tot < -half);
    end
  endfunction

  // Issue one op and wait for done; n = edges after the accept edge
  task automatic run_op(
    input int w, input bit l, input int op, input bit m,
    input longint a, input longint b,
    output longint r, output bit z, output bit c,
    output bit s, output bit v, output int n);
    bit dn;
    @(negedge clk);
    l_in = l;
    op_in = op[1:0];
    mul_in = m;
    a_in = a[31:0];
    b_in = b[31:0];
    if (w == 4) start4 = 1'b1;
    else start8 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    start8 = 1'b0;
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      dn = (w == 4) ? done4 : done8;
      if (dn) begin
        n = i;
        break;
      end
    end
    r = (w == 4) ? longint'(r4) : longint'(r8);
    z = (w == 4) ? z4 : z8;
    c = (w == 4) ? c4 : c8;
    s = (w == 4) ? s4 : s8;
    v = 1'b0;
`ifdef ALU_OVF_FLAG_EN
    v = (w == 4) ? v4 : v8;
`endif
    if (n < 0) begin
      total++;
      bad++;
      $display("FAIL timeout w=%0d: no done within 40 edges", w);
    end
  endtask

  task automatic test_reset();
    int seen;
    @(negedge clk);
    reset = 1'b1;
    l_in = 1'b0;
    op_in = 2'b10;
    mul_in = 1'b0;
    a_in = 32'd5;
    b_in = 32'd3;
    start4 = 1'b1;
    start8 = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    start4 = 1'b0;
    start8 = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy4 || done4 || busy8 || done8) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL reset_start: busy/done seen %0d need 0", seen);
    end
    total++;
    if (r8 !== 8'h00) begin
      bad++;
      $display("FAIL reset_r8: got %h need 00", r8);
    end
    total++;
    if ({z8, c8, s8} !== 3'b100) begin
      bad++;
      $display("FAIL reset_flags8: got %b need 100", {z8, c8, s8});
    end
    total++;
    if ({r4, z4, c4, s4} !== 7'b0000_100) begin
      bad++;
      $display("FAIL reset_w4: got %b need 0000100",
               {r4, z4, c4, s4});
    end
`ifdef ALU_OVF_FLAG_EN
    total++;
    if ({v4, v8} !== 2'b00) begin
      bad++;
      $display("FAIL reset_v: got %b need 00", {v4, v8});
    end
`endif
  endtask

  task automatic test_exhaustive4();
    longint r, er;
    bit z, c, s, v, ec, ev;
    int n;
    for (int l = 0; l < 2; l++)
      for (int op = 0; op < 4; op++)
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++) begin
            run_op(4, l[0], op, 1'b0, a, b, r, z, c, s, v, n);
            model(4, l[0], op, 1'b0, a, b, er, ec, ev);
            total++;
            if (r !== er || c !== ec || z !== (er == 0) ||
                s !== er[3] || n !== 1) begin
              bad++;
              $display("FAIL exh4 l=%0d op=%0d a=%0d b=%0d: r=%0d c=%0d z=%0d s=%0d n=%0d need r=%0d c=%0d",
                       l, op, a, b, r, c, z, s, n, er, ec);
            end
          end
  endtask

  task automatic test_key_values();
    longint r;
    bit z, c, s, v;
    int n;
    run_op(4, 1'b0, 3, 1'b0, 3, 5, r, z, c, s, v, n);
    total++;
    if (r !== 14 || c !== 0 || s !== 1 || z !== 0) begin
      bad++;
      $display("FAIL key_sub4: r=%0d c=%0d s=%0d z=%0d need 14 0 1 0",
               r, c, s, z);
    end
    run_op(4, 1'b0, 0, 1'b0, 15, 0, r, z, c, s, v, n);
    total++;
    if (r !== 0 || c !== 1 || z !== 1) begin
      bad++;
      $display("FAIL key_inc4: r=%0d c=%0d z=%0d need 0 1 1", r, c, z);
    end
    run_op(8, 1'b0, 0, 1'b1, 'h0F, 'h11, r, z, c, s, v, n);
    total++;
    if (r !== 'hFF || c !== 0 || s !== 1 || z !== 0) begin
      bad++;
      $display("FAIL key_mul_ff: r=%h c=%0d s=%0d need ff 0 1", r, c, s);
    end
    total++;
    if (n !== 8) begin
      bad++;
      $display("FAIL mul_latency: done %0d edges after accept need 8", n);
    end
    run_op(8, 1'b0, 0, 1'b1, 'h10, 'h10, r, z, c, s, v, n);
    total++;
    if (r !== 0 || c !== 1 || z !== 1) begin
      bad++;
      $display("FAIL key_mul_100: r=%h c=%0d z=%0d need 00 1 1", r, c, z);
    end
  endtask

  task automatic test_random8();
    longint r, er, a, b;
    bit z, c, s, v, ec, ev, l, m;
    int n, op;
    for (int i = 0; i < 300; i++) begin
      a = longint'($urandom_range(255));
      b = longint'($urandom_range(255));
      l = 1'($urandom_range(1));
      m = ($urandom_range(3) == 0);
      op = int'($urandom_range(3));
      run_op(8, l, op, m, a, b, r, z, c, s, v, n);
      model(8, l, op, m, a, b, er, ec, ev);
      total++;
      if (r !== er || c !== ec || z !== (er == 0) ||
          s !== er[7] || n !== (m ? 8 : 1)) begin
        bad++;
        $display("FAIL rand8 l=%0d op=%0d m=%0d a=%h b=%h: r=%h c=%0d n=%0d need r=%h c=%0d",
                 l, op, m, a, b, r, c, n, er, ec);
      end
`ifdef ALU_OVF_FLAG_EN
      total++;
      if (v !== (ev && !m && !l)) begin
        bad++;
        $display("FAIL rand8_v a=%h b=%h op=%0d: v=%0d need %0d",
                 a, b, op, v, ev && !m && !l);
      end
`endif
    end
  endtask

  task automatic test_busy_protect();
    int ndone, bad_busy, first;
    logic [7:0] rd;
    @(negedge clk);
    l_in = 1'b0;
    op_in = 2'b00;
    mul_in = 1'b1;
    a_in = 32'd3;
    b_in = 32'd5;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    ndone = 0;
    bad_busy = 0;
    first = -1;
    rd = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done8) begin
        ndone++;
        if (first < 0) begin
          first = i;
          rd = r8;
        end
      end
      if (first < 0 && !busy8) bad_busy++;
      if (first > 0 && busy8) bad_busy++;
      start8 = (i == 2);
      if (i == 2) begin
        l_in = 1'b1;
        mul_in = 1'b0;
        a_in = 32'hFF;
        b_in = 32'hFF;
      end
    end
    total++;
    if (rd !== 8'd15 || ndone !== 1 || first !== 8) begin
      bad++;
      $display("FAIL busy_protect: r=%0d dones=%0d at=%0d need 15 1 8",
               rd, ndone, first);
    end
    total++;
    if (bad_busy !== 0) begin
      bad++;
      $display("FAIL busy_level: %0d wrong busy samples need 0", bad_busy);
    end
  endtask

  task automatic test_reset_mid_mul();
    int ndone;
    longint r;
    bit z, c, s, v;
    int n;
    @(negedge clk);
    l_in = 1'b0;
    op_in = 2'b00;
    mul_in = 1'b1;
    a_in = 32'd7;
    b_in = 32'd9;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    total++;
    if (ndone !== 0 || r8 !== 8'd0 || busy8 !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_mul: dones=%0d r=%0d busy=%0d need 0 0 0",
               ndone, r8, busy8);
    end
    run_op(8, 1'b0, 0, 1'b1, 2, 3, r, z, c, s, v, n);
    total++;
    if (r !== 6 || n !== 8) begin
      bad++;
      $display("FAIL mul_after_reset: r=%0d n=%0d need 6 8", r, n);
    end
  endtask

  task automatic test_back_to_back();
    int ndone, badr;
    longint er;
    bit ec, ev;
    model(8, 1'b0, 2, 1'b0, 'h5A, 'h33, er, ec, ev);
    @(negedge clk);
    l_in = 1'b0;
    op_in = 2'b10;
    mul_in = 1'b0;
    a_in = 32'h5A;
    b_in = 32'h33;
    start8 = 1'b1;
    ndone = 0;
    badr = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (done8) begin
        ndone++;
        if (longint'(r8) !== er) badr++;
      end
    end
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (ndone !== 5 || badr !== 0) begin
      bad++;
      $display("FAIL back_to_back: dones=%0d badr=%0d need 5 0",
               ndone, badr);
    end
  endtask

`ifdef ALU_OVF_FLAG_EN
  task automatic test_ovf();
    longint r;
    bit z, c, s, v;
    int n;
    run_op(8, 1'b0, 2, 1'b0, 'h7F, 'h01, r, z, c, s, v, n);
    total++;
    if (r !== 'h80 || v !== 1 || c !== 0) begin
      bad++;
      $display("FAIL ovf_add: r=%h v=%0d c=%0d need 80 1 0", r, v, c);
    end
    run_op(8, 1'b0, 3, 1'b0, 'h80, 'h01, r, z, c, s, v, n);
    total++;
    if (r !== 'h7F || v !== 1) begin
      bad++;
      $display("FAIL ovf_sub: r=%h v=%0d need 7f 1", r, v);
    end
    run_op(8, 1'b0, 2, 1'b0, 'h01, 'h01, r, z, c, s, v, n);
    total++;
    if (r !== 'h02 || v !== 0) begin
      bad++;
      $display("FAIL ovf_none: r=%h v=%0d need 02 0", r, v);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_exhaustive4();
    test_key_values();
    test_random8();
    test_busy_protect();
    test_reset_mid_mul();
    test_back_to_back();
`ifdef ALU_OVF_FLAG_EN
    test_ovf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
